spi_cmd_master: RTL
===================

// Module: spi_cmd_master
// PURPOSE
//  Upstream SPI master for the SPI slave + single-port RAM wrapper. Takes RAM commands
//  (write-addr, write-data, read-addr, read-data) on a valid/ready interface, serialises
//  each as one SPI frame on ss_n/MOSI, and for read-data captures the 8-bit reply on MISO.
//  Shares the wrapper's clk; the wrapper samples MOSI on posedge clk.
// PARAMETERS
//  RD_WAIT    2  cycles between last command bit and first MISO sample (read-data only)
//  GAP_CYCLES 1  cycles ss_n held high between frames (>=1)
// PORTS
//  clk        in   1  system clock, shared with the wrapper
//  rst_n      in   1  asynchronous active-low reset
//  cmd_valid  in   1  command request
//  cmd_ready  out  1  high when a command can be accepted (state IDLE)
//  cmd_op     in   2  00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
//  cmd_data   in   8  address/data payload (don't-care for 11)
//  ss_n       out  1  slave select, active low
//  MOSI       out  1  serial data to slave
//  MISO       in   1  serial data from slave
//  rd_valid   out  1  one-cycle pulse: rd_data holds read-data reply
//  rd_data    out  8  last captured reply
//  busy       out  1  high whenever not IDLE
// BEHAVIOUR
//  Single clock domain; reset is asynchronous, active-low. All outputs registered
//  except cmd_ready (= state==IDLE) and busy (= !cmd_ready).
//  Reset values: ss_n=1, MOSI=0, rd_valid=0, rd_data=0, state IDLE (cmd_ready=1, busy=0).
//  Accept: posedge with cmd_valid&&cmd_ready latches word W={cmd_op,cmd_data} (10 bits).
//  FSM: IDLE -> SEL -> SHIFT -> (op==11 ? WAIT -> READ : GAP) -> GAP -> IDLE.
//  - SEL (1 cycle): ss_n=0, MOSI=W[9] (slave read/write selector bit).
//  - SHIFT (10 cycles): ss_n=0, MOSI=W[9]..W[0], MSB first, one bit per cycle.
//  - Frame on MOSI = 11 bits; ss_n falls the cycle after accept.
//  - op!=11: after SHIFT go to GAP; ss_n=1, MOSI=0.
//  - WAIT (RD_WAIT cycles): ss_n=0, MOSI=0.
//  - READ (8 cycles): ss_n=0, MOSI=0; shift MISO into rd_data MSB first at each posedge.
//    Exit: rd_valid=1 for exactly the first GAP cycle, rd_data stable until next reply.
//  - GAP (GAP_CYCLES): ss_n=1, MOSI=0; then IDLE. cmd_ready asserts after GAP.
//  Frame lengths incl. gap: write/rd-addr 1+10+GAP; rd-data 1+10+RD_WAIT+8+GAP cycles.
//  cmd_valid while busy: ignored, not queued; cmd_op/cmd_data only sampled at accept.
//  rd_data updated only by READ; other ops leave it unchanged.
//  No ordering enforcement: rd-data without prior rd-addr is still sent as framed.
//  Reset mid-frame: ss_n=1 immediately (async), frame aborted, no rd_valid, rd_data=0.
//  Counters: 4-bit bit counter (0..10), wait/gap counter sized $clog2(max(RD_WAIT,GAP)+1);
//  no wrap-around beyond terminal count.
// TESTING
//  1 Reset: rst_n=0 mid-SHIFT -> ss_n=1, MOSI=0, busy=0, cmd_ready=1 same cycle, no rd_valid.
//  2 wr-addr op=00 data=8'hA5 -> ss_n low 11 cycles, MOSI=0,0,0,1,0,1,0,0,1,0,1, then ss_n=1.
//  3 wr-data op=01 data=8'h3C after (2) -> MOSI=0,0,1,0,0,1,1,1,1,0,0; wrapper RAM[A5]=3C.
//  4 rd-addr op=10 A5 then rd-data op=11 on real wrapper -> rd_valid 1 pulse, rd_data=8'h3C.
//  5 MISO model drives 8'h81 after RD_WAIT=2 -> rd_data=8'h81; frame 1+10+2+8 low cycles.
//  6 Back-to-back cmd_valid held high -> 2nd accepted only after GAP; cmd_ready=0 while busy.

Source files
------------

// File: rtl/spi_cmd_master.sv
// SPI command master: serialises {op,data} RAM commands to the SPI RAM wrapper and,
// for read-data commands, captures the 8-bit reply from MISO.
module spi_cmd_master #(
  parameter int RD_WAIT    = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       ss_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       busy
);

  localparam int MAXW = (RD_WAIT > GAP_CYCLES) ? RD_WAIT : GAP_CYCLES;
  localparam int WCW  = $clog2(MAXW + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(RD_WAIT - 1);
  localparam logic [WCW-1:0] GAP_LAST  = WCW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_SHIFT, S_WAIT, S_READ, S_GAP
  } state_e;

  state_e         state_q, state_d;
  logic [9:0]     w_q, w_d;
  logic [3:0]     bcnt_q, bcnt_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [7:0]     sh_q, sh_d;
  logic           ss_n_q, ss_n_d;
  logic           mosi_q, mosi_d;
  logic           rd_valid_q, rd_valid_d;
  logic [7:0]     rd_data_q, rd_data_d;

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    bcnt_d     = bcnt_q;
    wcnt_d     = wcnt_q;
    sh_d       = sh_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          w_d     = {cmd_op, cmd_data};
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        bcnt_d  = 4'd0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (bcnt_q == 4'd9) begin
          wcnt_d  = '0;
          state_d = (w_q[9:8] == 2'b11) ? S_WAIT : S_GAP;
        end else begin
          bcnt_d = bcnt_q + 4'd1;
        end
      end
      S_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          bcnt_d  = 4'd0;
          state_d = S_READ;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      S_READ: begin
        sh_d = {sh_q[6:0], MISO};
        if (bcnt_q == 4'd7) begin
          // Publish the whole reply at once so rd_data never shows a partial byte.
          rd_data_d  = sh_d;
          rd_valid_d = 1'b1;
          wcnt_d     = '0;
          state_d    = S_GAP;
        end else begin
          bcnt_d = bcnt_q + 4'd1;
        end
      end
      S_GAP: begin
        if (wcnt_q == GAP_LAST) state_d = S_IDLE;
        else                    wcnt_d  = wcnt_q + WCW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Pins are registered from the next state so they line up with the state they belong to.
    ss_n_d = !(state_d inside {S_SEL, S_SHIFT, S_WAIT, S_READ});
    mosi_d = 1'b0;
    if (state_d == S_SEL)        mosi_d = w_d[9];
    else if (state_d == S_SHIFT) mosi_d = w_d[4'd9 - bcnt_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      w_q        <= '0;
      bcnt_q     <= '0;
      wcnt_q     <= '0;
      sh_q       <= '0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      bcnt_q     <= bcnt_d;
      wcnt_q     <= wcnt_d;
      sh_q       <= sh_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = !cmd_ready;
  assign ss_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule
